matrix_stream_engine: RTL and testbench
=======================================

Name: matrix_stream_engine

Overview:
Parametrised NxN matrix coprocessor on the UART byte path. It receives an opcode header and two matrices over a byte stream, then computes A*B or A+B with a single sequential MAC. It returns the result matrix row-major over a byte stream. It sits between the receiver and transmitter blocks, and adds valid/ready handshakes, runtime op select, configurable size and width, overflow handling and error reporting.

Parameters:
N, 2, matrix dimension (2..8)
DW, 8, element width in bits; multiple of 8 (8 or 16); elements carried as DW/8 bytes, LSB byte first
SAT, 1, 1 = saturate results to 2^DW-1; 0 = truncate to low DW bits
ERR_BYTE, 8'hEE, byte returned on an illegal opcode

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  byte available from receiver side
in_data  in  8  received byte
in_ready  out  1  engine accepts byte this cycle
out_valid  out  1  result byte available
out_data  out  8  result byte
out_ready  in  1  transmitter side accepts byte
busy  out  1  high in any state other than IDLE
op_done  out  1  one-cycle pulse after the last result byte is accepted
err  out  1  one-cycle pulse on illegal opcode
ovf  out  1  sticky: some result element exceeded DW bits in the current op; cleared on header accept

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. On reset: state=IDLE, all counters, A/B/C storage and accumulator = 0; in_ready=0, out_valid=0, out_data=0, op_done=0, err=0, ovf=0, busy=0.
- Transfer rules: a byte moves on in_valid&&in_ready or on out_valid&&out_ready. out_data is held stable while out_valid&&!out_ready.
- IDLE: in_ready=1.
  - Header 8'h01 = MUL, 8'h00 = ADD: latch op, clear ovf, go to LOAD_A.
  - Any other header: go to ERR.
- LOAD_A / LOAD_B: in_ready=1. Receive N*N*(DW/8) bytes, assembled LSB first into elements stored row-major (index r*N+c). After the last byte of A go to LOAD_B. After the last byte of B go to COMPUTE. The last byte is written in its accept cycle.
- COMPUTE: in_ready=0.
  - MUL: loops i,j,k, one MAC per cycle; acc = sum A[i][k]*B[k][j]. ACC_W = 2*DW + clog2(N), no internal overflow. C[i][j] is written the cycle after k=N-1. Total N^3+1 cycles.
  - ADD: C[i][j] = A[i][j]+B[i][j] at width DW+1, one element per cycle. Total N^2 cycles.
  - Writeback: if the value exceeds 2^DW-1, set ovf. Store 2^DW-1 if SAT=1, otherwise the low DW bits.
  - Then go to SEND.
- SEND: out_valid=1. Stream C row-major, LSB byte first; the byte/element counter advances only on a handshake. After the last byte is accepted: out_valid=0, op_done pulses for 1 cycle, go to IDLE. Next header is accepted the cycle after op_done.
- ERR: out_valid=1, out_data=ERR_BYTE. err pulses on ERR entry. On handshake go to IDLE; no op_done.
- Bytes arriving while in_ready=0 are not consumed; upstream holds them.
- Reset mid-operation aborts the op immediately; partial matrices are discarded.
- Counters wrap to 0 at each state exit. No state is reachable outside the six listed.

Decomposition:
- Package matrix_stream_pkg holds:
  - opcode constants OP_ADD=8'h00, OP_MUL=8'h01
  - state encoding IDLE, LOAD_A, LOAD_B, COMPUTE, SEND, ERR
  - clog2 function
- Sub-module mac_unit (DW x DW multiply, ACC_W accumulator, clear/enable inputs), instantiated once. The top holds the FSM, counters and element storage.

Test Plan:
1. N=2, DW=8. Send 01, A=1,2,3,4, B=5,6,7,8 -> out 19,22,43,50; op_done once; ovf=0.
2. Send 00, A=10,20,30,40, B=1,2,3,4 -> out 11,22,33,44; COMPUTE lasts 4 cycles.
3. SAT=1, MUL, A=16,16,0,0, B=16,0,16,0 -> out 255,0,0,0; ovf=1. SAT=0, same stimulus -> out 0,0,0,0; ovf=1. Next ADD with no overflow -> ovf=0.
4. Header 7F -> err pulse, single out byte EE, return to IDLE; following valid MUL packet correct.
5. Test 1 with out_ready toggling randomly and in_valid gaps -> identical bytes, out_data stable while stalled, in_ready=0 throughout COMPUTE/SEND.
6. Assert rst after 2 bytes of B -> all outputs at reset values. Rerun test 1 -> correct. Also N=3, DW=16: identity A, B=1..9 -> B returned, 18 bytes, LSB first.

Source files
------------

// File: rtl/matrix_stream_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the matrix stream engine.
package matrix_stream_pkg;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_MUL = 8'h01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    ERR     = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 0; p < 31; p++) begin
      if ((1 << p) < v) r = p + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate slice: acc += a*b, with clear that restarts the sum.
module mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-2*DW){1'b0}}, prod};

  // clr together with en loads the first product of a new dot product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? '0 : acc) + prod_ext;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/matrix_stream_engine.sv
// NxN matrix coprocessor on a byte stream: header, A, B in; A*B or A+B computed
// with one sequential MAC; result streamed out row-major, LSB byte first.
module matrix_stream_engine
  import matrix_stream_pkg::*;
#(
  parameter int          N        = 2,
  parameter int          DW       = 8,
  parameter int          SAT      = 1,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       op_done,
  output logic       err,
  output logic       ovf
);

  localparam int NE    = N * N;
  localparam int NB    = DW / 8;
  localparam int EW    = clog2(NE);
  localparam int BW    = (NB > 1) ? clog2(NB) : 1;
  localparam int IW    = clog2(N);
  localparam int ACC_W = 2 * DW + clog2(N);

  state_t            state;
  logic              op_mul;
  logic [EW-1:0]     ecnt;
  logic [BW-1:0]     bcnt;
  logic [IW-1:0]     i_cnt, j_cnt, k_cnt;
  logic              wb;
  logic [EW-1:0]     wb_idx;
  logic              mac_done;

  logic [DW-1:0]     a_m [NE];
  logic [DW-1:0]     b_m [NE];
  logic [DW-1:0]     c_m [NE];

  logic [EW-1:0]     a_idx, b_idx;
  logic              mac_en, mac_clr;
  logic [ACC_W-1:0]  acc;
  logic [DW:0]       sum_add;
  logic [ACC_W-1:0]  wb_src;
  logic              c_we, c_over;
  logic [EW-1:0]     c_widx;
  logic [DW-1:0]     c_wval;
  logic              in_hs, out_hs, last_byte, last_elem;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_byte = (bcnt == BW'(NB - 1));
  assign last_elem = (ecnt == EW'(NE - 1));

  assign a_idx   = EW'(i_cnt * N + k_cnt);
  assign b_idx   = EW'(k_cnt * N + j_cnt);
  assign mac_en  = (state == COMPUTE) && op_mul && !mac_done;
  assign mac_clr = (k_cnt == '0);

  mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_m[a_idx]),
    .b   (b_m[b_idx]),
    .acc (acc)
  );

  // One writeback path serves both ops; MUL retires the element finished last cycle
  always_comb begin
    sum_add = {1'b0, a_m[ecnt]} + {1'b0, b_m[ecnt]};
    wb_src  = op_mul ? acc : ACC_W'(sum_add);
    c_over  = |wb_src[ACC_W-1:DW];
    c_wval  = (c_over && (SAT != 0)) ? '1 : wb_src[DW-1:0];
    c_widx  = op_mul ? wb_idx : ecnt;
    c_we    = (state == COMPUTE) && (op_mul ? wb : 1'b1);
  end

  always_comb begin
    out_data = '0;
    if (state == ERR) begin
      out_data = ERR_BYTE;
    end else if (state == SEND) begin
      for (int q = 0; q < NB; q++) begin
        if (bcnt == BW'(q)) out_data = c_m[ecnt][8*q +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_mul    <= 1'b0;
      ecnt      <= '0;
      bcnt      <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      wb        <= 1'b0;
      wb_idx    <= '0;
      mac_done  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_done   <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      for (int e = 0; e < NE; e++) begin
        a_m[e] <= '0;
        b_m[e] <= '0;
        c_m[e] <= '0;
      end
    end else begin
      op_done <= 1'b0;
      err     <= 1'b0;
      if (c_we) begin
        c_m[c_widx] <= c_wval;
        if (c_over) ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            busy <= 1'b1;
            if (in_data == OP_MUL || in_data == OP_ADD) begin
              op_mul <= (in_data == OP_MUL);
              ovf    <= 1'b0;
              state  <= LOAD_A;
            end else begin
              err       <= 1'b1;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ERR;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_hs) begin
            for (int q = 0; q < NB; q++) begin
              if (bcnt == BW'(q)) begin
                if (state == LOAD_A) a_m[ecnt][8*q +: 8] <= in_data;
                else                 b_m[ecnt][8*q +: 8] <= in_data;
              end
            end
            if (last_byte) begin
              bcnt <= '0;
              if (last_elem) begin
                ecnt <= '0;
                if (state == LOAD_A) begin
                  state <= LOAD_B;
                end else begin
                  state    <= COMPUTE;
                  in_ready <= 1'b0;
                end
              end else begin
                ecnt <= ecnt + 1'b1;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (!op_mul) begin
            if (last_elem) begin
              ecnt      <= '0;
              out_valid <= 1'b1;
              state     <= SEND;
            end else begin
              ecnt <= ecnt + 1'b1;
            end
          end else if (!mac_done) begin
            wb <= 1'b0;
            if (k_cnt == IW'(N - 1)) begin
              k_cnt  <= '0;
              wb     <= 1'b1;
              wb_idx <= EW'(i_cnt * N + j_cnt);
              if (j_cnt == IW'(N - 1)) begin
                j_cnt <= '0;
                if (i_cnt == IW'(N - 1)) begin
                  i_cnt    <= '0;
                  mac_done <= 1'b1;
                end else begin
                  i_cnt <= i_cnt + 1'b1;
                end
              end else begin
                j_cnt <= j_cnt + 1'b1;
              end
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end else begin
            // drain cycle: the last dot product is written back above
            wb        <= 1'b0;
            mac_done  <= 1'b0;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_hs) begin
            if (last_byte) begin
              bcnt <= '0;
              if (last_elem) begin
                ecnt      <= '0;
                out_valid <= 1'b0;
                op_done   <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                ecnt <= ecnt + 1'b1;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ERR: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_engine.sv
// Bench for matrix_stream_engine: three configurations driven from one byte driver,
// results compared against a plain-arithmetic matrix model.
module tb_matrix_stream_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic       drv_ready;
  int         sel;

  logic [2:0] iv, ordy, ir, ov, bz, dn, er, of;
  logic [7:0] od [3];

  always #5 clk = ~clk;

  assign iv   = drv_valid ? 3'(3'b001 << sel) : 3'b000;
  assign ordy = drv_ready ? 3'(3'b001 << sel) : 3'b000;

  matrix_stream_engine #(.N(2), .DW(8), .SAT(1), .ERR_BYTE(8'hEE)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(drv_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .busy(bz[0]),
    .op_done(dn[0]), .err(er[0]), .ovf(of[0]));

  matrix_stream_engine #(.N(2), .DW(8), .SAT(0), .ERR_BYTE(8'hEE)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(drv_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .busy(bz[1]),
    .op_done(dn[1]), .err(er[1]), .ovf(of[1]));

  matrix_stream_engine #(.N(3), .DW(16), .SAT(1), .ERR_BYTE(8'hEE)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(drv_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]), .busy(bz[2]),
    .op_done(dn[2]), .err(er[2]), .ovf(of[2]));

  int checks = 0;
  int fails  = 0;
  int n_cur, dw_cur, sat_cur;
  int ma [81];
  int mb [81];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic exp_ovf;
  int comp_cyc, stab_viol, ir_viol, err_cnt, done_cnt, timeouts;
  logic busy_mid, ir_after, ov_after;

  task automatic use_dut(input int k);
    sel     = k;
    n_cur   = (k == 2) ? 3 : 2;
    dw_cur  = (k == 2) ? 16 : 8;
    sat_cur = (k == 1) ? 0 : 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (er[sel]) err_cnt++;
    if (dn[sel]) done_cnt++;
  endtask

  // Reference: whole-matrix arithmetic, then clamp/truncate and serialise LSB first
  task automatic build_expected(input logic [7:0] hdr);
    longint maxv, s;
    exp_q.delete();
    exp_ovf = 1'b0;
    if (hdr != 8'h00 && hdr != 8'h01) begin
      exp_q.push_back(8'hEE);
      return;
    end
    maxv = (longint'(1) << dw_cur) - 1;
    for (int r = 0; r < n_cur; r++) begin
      for (int c = 0; c < n_cur; c++) begin
        s = 0;
        if (hdr == 8'h01) begin
          for (int k = 0; k < n_cur; k++)
            s += longint'(ma[r*n_cur+k]) * longint'(mb[k*n_cur+c]);
        end else begin
          s = longint'(ma[r*n_cur+c]) + longint'(mb[r*n_cur+c]);
        end
        if (s > maxv) begin
          exp_ovf = 1'b1;
          s = (sat_cur != 0) ? maxv : (s & maxv);
        end
        for (int q = 0; q < dw_cur/8; q++) exp_q.push_back(8'((s >> (8*q)) & 255));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic acc;
    drv_data  = b;
    drv_valid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 1000) begin
      acc = ir[sel];
      tick();
      guard++;
    end
    drv_valid = 1'b0;
    if (!acc) timeouts++;
  endtask

  task automatic run_op(input logic [7:0] hdr, input bit stall);
    logic       legal, held_vld;
    logic [7:0] held;
    int         v, nexp, guard;
    err_cnt = 0; done_cnt = 0; timeouts = 0; stab_viol = 0; ir_viol = 0;
    got_q.delete();
    held = '0;
    legal = (hdr == 8'h00 || hdr == 8'h01);
    send_byte(hdr);
    if (legal) begin
      for (int m = 0; m < 2; m++)
        for (int e = 0; e < n_cur*n_cur; e++)
          for (int q = 0; q < dw_cur/8; q++) begin
            if (stall && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
            v = (m == 0) ? ma[e] : mb[e];
            send_byte(8'((v >> (8*q)) & 255));
          end
    end
    comp_cyc = 0;
    while (!ov[sel] && comp_cyc < 2000) begin
      if (ir[sel]) ir_viol++;
      tick();
      comp_cyc++;
    end
    busy_mid = bz[sel];
    nexp = legal ? n_cur*n_cur*dw_cur/8 : 1;
    held_vld = 1'b0;
    guard = 0;
    while (got_q.size() < nexp && guard < 5000) begin
      drv_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ov[sel]) begin
        if (ir[sel]) ir_viol++;
        if (held_vld && od[sel] !== held) stab_viol++;
        if (drv_ready) begin
          got_q.push_back(od[sel]);
          held_vld = 1'b0;
        end else begin
          held     = od[sel];
          held_vld = 1'b1;
        end
      end
      tick();
      guard++;
    end
    drv_ready = 1'b0;
    if (got_q.size() < nexp) timeouts++;
    ir_after = ir[sel];
    ov_after = ov[sel];
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_valid = 1'b0; drv_data = '0; drv_ready = 1'b0;
    use_dut(0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir[0] !== 1'b0) begin fails++; $display("FAIL reset in_ready got %b want 0", ir[0]); end
    checks++; if (ov[0] !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", ov[0]); end
    checks++; if (od[0] !== 8'h00) begin fails++; $display("FAIL reset out_data got %h want 00", od[0]); end
    checks++; if ({bz[0], dn[0], er[0], of[0]} !== 4'b0) begin fails++; $display("FAIL reset busy/done/err/ovf got %b want 0000", {bz[0], dn[0], er[0], of[0]}); end
    rst = 1'b0;
    tick();
    checks++; if (ir[0] !== 1'b1) begin fails++; $display("FAIL idle in_ready got %b want 1", ir[0]); end
  endtask

  task automatic load_test1();
    for (int e = 0; e < 4; e++) begin ma[e] = e + 1; mb[e] = e + 5; end
  endtask

  task automatic test_mul(input string name, input bit stall);
    use_dut(0);
    load_test1();
    build_expected(8'h01);
    run_op(8'h01, stall);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL %s byte%0d got %h want %h", name, i, got_q[i], exp_q[i]); end
    end
    checks++; if (timeouts != 0) begin fails++; $display("FAIL %s timeouts got %0d want 0", name, timeouts); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL %s op_done pulses got %0d want 1", name, done_cnt); end
    checks++; if (of[0] !== exp_ovf) begin fails++; $display("FAIL %s ovf got %b want %b", name, of[0], exp_ovf); end
    checks++; if (comp_cyc != 9) begin fails++; $display("FAIL %s compute cycles got %0d want 9", name, comp_cyc); end
    checks++; if (ir_viol != 0 || stab_viol != 0) begin fails++; $display("FAIL %s in_ready/stability violations got %0d/%0d want 0/0", name, ir_viol, stab_viol); end
    checks++; if (busy_mid !== 1'b1 || bz[0] !== 1'b0) begin fails++; $display("FAIL %s busy mid/after got %b/%b want 1/0", name, busy_mid, bz[0]); end
    checks++; if (ir_after !== 1'b0 || ov_after !== 1'b0) begin fails++; $display("FAIL %s in_ready/out_valid at op_done got %b/%b want 0/0", name, ir_after, ov_after); end
  endtask

  task automatic test_add();
    use_dut(0);
    for (int e = 0; e < 4; e++) begin ma[e] = 10 * (e + 1); mb[e] = e + 1; end
    build_expected(8'h00);
    run_op(8'h00, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL add byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (comp_cyc != 4) begin fails++; $display("FAIL add compute cycles got %0d want 4", comp_cyc); end
    checks++; if (done_cnt != 1 || timeouts != 0) begin fails++; $display("FAIL add done/timeouts got %0d/%0d want 1/0", done_cnt, timeouts); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      use_dut(k);
      ma[0] = 16; ma[1] = 16; ma[2] = 0; ma[3] = 0;
      mb[0] = 16; mb[1] = 0;  mb[2] = 16; mb[3] = 0;
      build_expected(8'h01);
      run_op(8'h01, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_sat%0d byte%0d got %h want %h", sat_cur, i, got_q[i], exp_q[i]); end
      end
      checks++; if (of[k] !== exp_ovf) begin fails++; $display("FAIL ovf_sat%0d flag got %b want %b", sat_cur, of[k], exp_ovf); end
    end
    for (int e = 0; e < 4; e++) begin ma[e] = e; mb[e] = 3; end
    build_expected(8'h00);
    run_op(8'h00, 1'b0);
    checks++; if (of[1] !== exp_ovf) begin fails++; $display("FAIL ovf_clear flag got %b want %b", of[1], exp_ovf); end
  endtask

  task automatic test_error();
    use_dut(0);
    build_expected(8'h7F);
    run_op(8'h7F, 1'b0);
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin fails++; $display("FAIL err byte got %h (n=%0d) want %h", got_q[0], got_q.size(), exp_q[0]); end
    checks++; if (err_cnt != 1) begin fails++; $display("FAIL err pulses got %0d want 1", err_cnt); end
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL err op_done pulses got %0d want 0", done_cnt); end
    checks++; if (bz[0] !== 1'b0 || ir[0] !== 1'b1) begin fails++; $display("FAIL err return busy/in_ready got %b/%b want 0/1", bz[0], ir[0]); end
    test_mul("after_err", 1'b0);
  endtask

  task automatic test_reset_midop();
    use_dut(0);
    timeouts = 0;
    send_byte(8'h01);
    for (int e = 0; e < 6; e++) send_byte(8'(e + 3));
    checks++; if (bz[0] !== 1'b1) begin fails++; $display("FAIL midop busy before reset got %b want 1", bz[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ir[0], ov[0], bz[0], dn[0], er[0], of[0]} !== 6'b0 || od[0] !== 8'h00) begin
      fails++; $display("FAIL midop reset outputs got %b/%h want 000000/00", {ir[0], ov[0], bz[0], dn[0], er[0], of[0]}, od[0]);
    end
    tick();
    rst = 1'b0;
    tick();
    test_mul("after_rst", 1'b0);
  endtask

  task automatic test_wide();
    use_dut(2);
    for (int e = 0; e < 9; e++) begin ma[e] = (e % 4 == 0) ? 1 : 0; mb[e] = e + 1; end
    build_expected(8'h01);
    run_op(8'h01, 1'b0);
    checks++; if (got_q.size() != 18) begin fails++; $display("FAIL wide byte count got %0d want 18", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL wide byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (comp_cyc != 28) begin fails++; $display("FAIL wide compute cycles got %0d want 28", comp_cyc); end
  endtask

  task automatic test_random();
    logic [7:0] hdr;
    for (int it = 0; it < 6; it++) begin
      use_dut(it % 3);
      for (int e = 0; e < n_cur*n_cur; e++) begin
        ma[e] = $urandom_range(0, (1 << dw_cur) - 1);
        mb[e] = $urandom_range(0, (1 << dw_cur) - 1);
      end
      hdr = 8'($urandom_range(0, 1));
      build_expected(hdr);
      run_op(hdr, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d byte%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
      checks++; if (of[sel] !== exp_ovf) begin fails++; $display("FAIL rand%0d ovf got %b want %b", it, of[sel], exp_ovf); end
      checks++; if (stab_viol != 0 || ir_viol != 0 || timeouts != 0 || done_cnt != 1) begin
        fails++; $display("FAIL rand%0d stab/inrdy/timeout/done got %0d/%0d/%0d/%0d want 0/0/0/1", it, stab_viol, ir_viol, timeouts, done_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul("mul", 1'b0);
    test_add();
    test_overflow();
    test_error();
    test_mul("mul_stall", 1'b1);
    test_reset_midop();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
